wb_b4_initiator: RTL and testbench

- Single-outstanding Wishbone B4 classic-cycle master (initiator) for the peripheral macro's slave port.
- Converts a valid/ready command stream into one bus read or write per command.
- Returns read data and a completion status over a valid/ready response stream.
- Bounds every cycle with a timeout so an unmapped or stuck slave cannot hang the requester.

---
 rtl/wb_initiator_pkg.sv | 15 +
 rtl/wb_timeout_counter.sv | 31 +++
 rtl/wb_b4_initiator.sv | 153 +++++++++++++++
 tb/tb_wb_b4_initiator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types for the Wishbone B4 classic initiator.
// Status codes and FSM state encoding.
package wb_initiator_pkg;

    localparam logic [1:0] WB_ST_OK      = 2'b00;
    localparam logic [1:0] WB_ST_BUS_ERR = 2'b01;
    localparam logic [1:0] WB_ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } wb_state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter with expiry flag for bus timeouts.
// TIMEOUT_CYCLES of 0 disables expiry.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TOW            = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TOW-1:0] LP_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TOW'(TIMEOUT_CYCLES - 1);

    logic [TOW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_LAST);

endmodule

// File: rtl/wb_b4_initiator.sv
// Single-outstanding Wishbone B4 classic initiator.
// One bus cycle per command; response returned via valid/ready.
module wb_b4_initiator
    import wb_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TOW            = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic [1:0]  rsp_status,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy_o
);

    wb_state_t   r_state;
    wb_state_t   w_next;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_we;
    logic        r_cyc;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic [1:0]  r_rsp_status;

    logic        w_accept;
    logic        w_done;
    logic        w_cnt_en;
    logic        w_expired;
    logic [1:0]  w_st;
    logic [31:0] w_rdat;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TOW           (TOW)
    ) u_tmo (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .i_clr    (w_accept),
        .i_en     (w_cnt_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ERR outranks ACK, and either outranks the timeout edge.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_cnt_en = 1'b0;
        w_st     = WB_ST_OK;
        w_rdat   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wbm_err_i) begin
                    w_done = 1'b1;
                    w_st   = WB_ST_BUS_ERR;
                end else if (wbm_ack_i) begin
                    w_done = 1'b1;
                    w_rdat = r_we ? 32'h0 : wbm_dat_i;
                end else if (w_expired) begin
                    w_done = 1'b1;
                    w_st   = WB_ST_TIMEOUT;
                end else begin
                    w_cnt_en = 1'b1;
                end
                if (w_done) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_we         <= 1'b0;
            r_cyc        <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= '0;
        end else begin
            if (w_accept) begin
                r_adr <= req_adr;
                r_dat <= req_dat;
                r_sel <= req_sel;
                r_we  <= req_we;
                r_cyc <= 1'b1;
            end
            if (w_done) begin
                r_cyc        <= 1'b0;
                r_rsp_valid  <= 1'b1;
                r_rsp_dat    <= w_rdat;
                r_rsp_status <= w_st;
            end
            if ((r_state == ST_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy_o     = (r_state != ST_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dat    = r_rsp_dat;
    assign rsp_status = r_rsp_status;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_dat;
    assign wbm_sel_o  = r_sel;
    assign wbm_we_o   = r_we;
    assign wbm_cyc_o  = r_cyc;
    assign wbm_stb_o  = r_cyc;

endmodule

// File: tb/tb_wb_b4_initiator.sv
// Randomized self-checking bench for wb_b4_initiator.
// Slave behaviour and expected results come from a transaction-level model.
module tb_wb_b4_initiator;

    localparam int TMO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    wb_b4_initiator #(
        .TIMEOUT_CYCLES(TMO),
        .TOW           (8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_status(rsp_status),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .busy_o    (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // kind: 0 silent slave, 1 ack, 2 err, 3 ack+err; asserted after d stb cycles
    task automatic run_txn(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int d, input int kind,
                           input logic [31:0] rd, input int hold,
                           input logic keep_req);
        int          n;
        int          exp_n;
        logic [1:0]  exp_st;
        logic [31:0] exp_dat;
        if (kind != 0 && d < TMO) begin
            exp_n = d + 1;
            if (kind >= 2) begin
                exp_st  = 2'b01;
                exp_dat = 32'h0;
            end else begin
                exp_st  = 2'b00;
                exp_dat = we ? 32'h0 : rd;
            end
        end else begin
            exp_n   = TMO;
            exp_st  = 2'b10;
            exp_dat = 32'h0;
        end

        @(negedge wb_clk_i);
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_dat   = dat;
        req_sel   = sel;
        check("req_ready_idle", req_ready, 1);
        @(posedge wb_clk_i);
        #1;
        if (!keep_req) req_valid = 1'b0;
        check("cyc_start", wbm_cyc_o, 1);
        check("stb_start", wbm_stb_o, 1);
        check("busy_bus", busy_o, 1);

        n = 0;
        while (wbm_cyc_o && n < 40) begin
            @(negedge wb_clk_i);
            check("adr_hold", wbm_adr_o, adr);
            check("dat_hold", wbm_dat_o, dat);
            check("sel_hold", wbm_sel_o, sel);
            check("we_hold", wbm_we_o, we);
            check("req_ready_bus", req_ready, 0);
            if (n == d && kind != 0) begin
                wbm_ack_i = (kind == 1 || kind == 3);
                wbm_err_i = (kind >= 2);
                wbm_dat_i = rd;
            end
            @(posedge wb_clk_i);
            #1;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            wbm_dat_i = $urandom;
            n++;
        end
        check("cyc_len", n, exp_n);
        check("stb_end", wbm_stb_o, 0);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_status", rsp_status, exp_st);
        check("rsp_dat", rsp_dat, exp_dat);

        for (int h = 0; h < hold; h++) begin
            @(negedge wb_clk_i);
            check("bp_valid", rsp_valid, 1);
            check("bp_status", rsp_status, exp_st);
            check("bp_dat", rsp_dat, exp_dat);
            check("bp_cyc", wbm_cyc_o, 0);
            check("bp_req_ready", req_ready, 0);
            if (h == 1) begin
                wbm_ack_i = 1'b1;
                wbm_err_i = 1'($urandom_range(0, 1));
            end
            @(posedge wb_clk_i);
            #1;
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
        end

        @(negedge wb_clk_i);
        check("hs_valid", rsp_valid, 1);
        check("hs_status", rsp_status, exp_st);
        check("hs_dat", rsp_dat, exp_dat);
        rsp_ready = 1'b1;
        @(posedge wb_clk_i);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
        check("post_cyc", wbm_cyc_o, 0);
        check("post_busy", busy_o, 0);

        @(negedge wb_clk_i);
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'($urandom_range(0, 1));
        @(posedge wb_clk_i);
        #1;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        check("idle_ack_ready", req_ready, 1);
        check("idle_ack_cyc", wbm_cyc_o, 0);
        check("idle_ack_rsp", rsp_valid, 0);
    endtask

    task automatic reset_mid_cycle();
        @(negedge wb_clk_i);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h0000_3000;
        req_dat   = 32'h1234_5678;
        req_sel   = 4'hF;
        @(posedge wb_clk_i);
        #1;
        req_valid = 1'b0;
        check("rst_pre_cyc", wbm_cyc_o, 1);
        repeat (2) @(posedge wb_clk_i);
        #3;
        wb_rst_i = 1'b1;
        #1;
        check("rst_cyc", wbm_cyc_o, 0);
        check("rst_stb", wbm_stb_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy_o, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge wb_clk_i);
            #1;
            check("rst_after_ready", req_ready, 1);
            check("rst_after_rsp", rsp_valid, 0);
            check("rst_after_cyc", wbm_cyc_o, 0);
        end
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_adr   = '0;
        req_dat   = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        wbm_dat_i = '0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid0", rsp_valid, 0);
        check("rst_cyc0", wbm_cyc_o, 0);
        check("rst_stb0", wbm_stb_o, 0);
        check("rst_adr0", wbm_adr_o, 0);
        check("rst_rsp_dat0", rsp_dat, 0);
        check("rst_status0", rsp_status, 0);
        check("rst_busy0", busy_o, 0);
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        run_txn(1'b0, 32'h0000_1004, 32'h0, 4'hF, 1, 1, 32'hA5A5_0033, 0, 1'b0);
        run_txn(1'b1, 32'h0000_2008, 32'hDEAD_BEEF, 4'b0011, 2, 1,
                32'hFFFF_FFFF, 0, 1'b0);
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 3, 32'h5555_AAAA, 1, 1'b0);
        run_txn(1'b0, 32'h0000_0044, 32'h0, 4'hF, 0, 0, 32'h0, 3, 1'b0);
        run_txn(1'b0, 32'h0000_0048, 32'h0, 4'hF, 15, 1, 32'h0BAD_F00D, 0, 1'b0);
        run_txn(1'b1, 32'h0000_004C, 32'h0C0F_FEE0, 4'hC, 0, 2, 32'h1, 10, 1'b1);
        reset_mid_cycle();

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 20),
                    $urandom_range(0, 3), $urandom, $urandom_range(0, 4),
                    1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
